// File: rtl/bcd_pkg.sv
// Shared constants, digit type and BCD validity check for the multi-digit BCD counter.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  typedef logic [3:0] digit_t;

  function automatic logic is_bcd(input digit_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: parallel load with sanitising, or a single up/down step with 9<->0 rollover.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   step,
  input  logic   up,
  input  logic   load,
  input  digit_t din,
  output digit_t q,
  output logic   at_max,
  output logic   at_min
);

  assign at_max = (q == BCD_MAX);
  assign at_min = (q == BCD_MIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= BCD_MIN;
    end else if (load) begin
      // An out-of-range load digit is forced to zero so q never holds A-F.
      q <= is_bcd(din) ? din : BCD_MIN;
    end else if (step) begin
      if (up) q <= at_max ? BCD_MIN : q + 4'd1;
      else    q <= at_min ? BCD_MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter_multi.sv
// Multi-digit up/down BCD counter with load validation and cascade terminal count.
// Define BCD_CNT_SATURATE_EN to hold at all-9 / all-0 instead of wrapping.
module bcd_counter_multi
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] din,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                load_err
);

  logic [DIGITS:0]   chain_max;
  logic [DIGITS:0]   chain_min;
  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] bad_digit;
  logic              all_max;
  logic              all_min;
  logic              sat_hold;
  logic              advance;

  // chain_*[k] is high when every digit below k is at 9 (or 0): carry/borrow into digit k.
  assign chain_max[0] = 1'b1;
  assign chain_min[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .rst    (rst),
      .step   (advance & (up ? chain_max[k] : chain_min[k])),
      .up     (up),
      .load   (load),
      .din    (din[4*k +: 4]),
      .q      (count[4*k +: 4]),
      .at_max (at_max[k]),
      .at_min (at_min[k])
    );
    assign chain_max[k+1] = chain_max[k] & at_max[k];
    assign chain_min[k+1] = chain_min[k] & at_min[k];
    assign bad_digit[k]   = ~is_bcd(din[4*k +: 4]);
  end

  assign all_max = chain_max[DIGITS];
  assign all_min = chain_min[DIGITS];

`ifdef BCD_CNT_SATURATE_EN
  assign sat_hold = up ? all_max : all_min;
`else
  assign sat_hold = 1'b0;
`endif

  assign advance = en & ~load & ~sat_hold;

  // tc ignores saturation so a downstream stage still sees the terminal event.
  assign tc = en & ~load & (up ? all_max : all_min);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      load_err <= 1'b0;
    else if (load) load_err <= |bad_digit;
  end

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Self-checking bench for bcd_counter_multi: single DIGITS=2 instance plus a two-stage cascade.
module tb_bcd_counter_multi;

  localparam int W = 17;

`ifdef BCD_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // main DUT
  logic       en = 1'b0, up = 1'b1, load = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] count;
  logic       tc, load_err;

  bcd_counter_multi #(.DIGITS(2)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .count(count), .tc(tc), .load_err(load_err)
  );

  // cascade: c1 is enabled by the terminal count of c0
  logic        c_en = 1'b0, c_load = 1'b0;
  logic [15:0] c_din = 16'h0000;
  logic [7:0]  c_count0, c_count1;
  logic        c_tc0, c_tc1, c_err0, c_err1;

  bcd_counter_multi #(.DIGITS(2)) u_c0 (
    .clk(clk), .rst(rst), .en(c_en), .up(1'b1), .load(c_load), .din(c_din[7:0]),
    .count(c_count0), .tc(c_tc0), .load_err(c_err0)
  );
  bcd_counter_multi #(.DIGITS(2)) u_c1 (
    .clk(clk), .rst(rst), .en(c_tc0), .up(1'b1), .load(c_load), .din(c_din[15:8]),
    .count(c_count1), .tc(c_tc1), .load_err(c_err1)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int m_val = 0;
  logic m_err = 1'b0;
  int c_lo = 0, c_hi = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int sanitize2(input logic [7:0] d);
    int hi, lo;
    hi = (d[7:4] > 4'd9) ? 0 : int'(d[7:4]);
    lo = (d[3:0] > 4'd9) ? 0 : int'(d[3:0]);
    return hi * 10 + lo;
  endfunction

  function automatic int step2(input int v, input logic u);
    if (u) return (v == 99) ? (SAT ? 99 : 0) : v + 1;
    return (v == 0) ? (SAT ? 0 : 99) : v - 1;
  endfunction

  // driver: called at a falling edge, drives one cycle, checks tc, then pops after the rising edge
  task automatic cycle_main(input logic e, input logic u, input logic l, input logic [7:0] d);
    logic [W-1:0] exp;
    en = e; up = u; load = l; din = d;
    #1;
    check("tc", {31'b0, tc}, {31'b0, e & ~l & (u ? (m_val == 99) : (m_val == 0))});
    if (l) begin
      m_val = sanitize2(d);
      m_err = (d[7:4] > 4'd9) | (d[3:0] > 4'd9);
    end else if (e) begin
      m_val = step2(m_val, u);
    end
    exp_q.push_back({8'b0, m_err, to_bcd2(m_val)});
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    check("count_err", {15'b0, load_err, count}, {15'b0, exp});
    @(negedge clk);
  endtask

  task automatic cycle_casc(input logic e, input logic l, input logic [15:0] d);
    logic [W-1:0] exp;
    logic t0;
    c_en = e; c_load = l; c_din = d;
    #1;
    t0 = e & ~l & (c_lo == 99);
    check("c_tc_upper", {31'b0, c_tc1}, {31'b0, t0 & (c_hi == 99)});
    if (l) begin
      c_lo = sanitize2(d[7:0]);
      c_hi = sanitize2(d[15:8]);
    end else begin
      if (t0) c_hi = step2(c_hi, 1'b1);
      if (e)  c_lo = step2(c_lo, 1'b1);
    end
    exp_q.push_back({1'b0, to_bcd2(c_hi), to_bcd2(c_lo)});
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    check("c_count", {15'b0, 1'b0, c_count1, c_count0}, {15'b0, exp});
    @(negedge clk);
  endtask

  initial begin
    // reset
    #12;
    check("rst_count", {24'b0, count}, 32'h0);
    check("rst_err", {31'b0, load_err}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // full up sequence 00..99 then 00
    for (int i = 0; i < 100; i++) cycle_main(1'b1, 1'b1, 1'b0, 8'h00);
    check("wrap_to_00", {24'b0, count}, 32'h0);

    // decrement from 00 (wrap or saturate)
    cycle_main(1'b1, 1'b0, 1'b0, 8'h00);

    // load priority over enable, valid and invalid loads
    cycle_main(1'b1, 1'b1, 1'b1, 8'h47);
    cycle_main(1'b1, 1'b1, 1'b1, 8'h3C);
    for (int i = 0; i < 3; i++) cycle_main(1'b1, 1'b1, 1'b0, 8'h00);
    cycle_main(1'b0, 1'b1, 1'b1, 8'h12);
    cycle_main(1'b0, 1'b0, 1'b1, 8'hF9);
    cycle_main(1'b1, 1'b0, 1'b1, 8'h00);
    cycle_main(1'b1, 1'b1, 1'b1, 8'h99);
    cycle_main(1'b1, 1'b1, 1'b0, 8'h00);

    // random mix
    for (int i = 0; i < 300; i++)
      cycle_main(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)));

    // asynchronous reset mid-count
    cycle_main(1'b0, 1'b1, 1'b1, 8'h58);
    #2 rst = 1'b0;
    #1;
    check("async_rst_count", {24'b0, count}, 32'h0);
    check("async_rst_err", {31'b0, load_err}, 32'h0);
    m_val = 0; m_err = 1'b0; c_lo = 0; c_hi = 0;
    @(negedge clk);
    rst = 1'b1;
    cycle_main(1'b1, 1'b1, 1'b0, 8'h00);

    // cascade: 0098 -> 0099 -> 0100, then 9998 -> 9999 -> wrap/hold
    cycle_casc(1'b1, 1'b1, 16'h0098);
    cycle_casc(1'b1, 1'b0, 16'h0000);
    cycle_casc(1'b1, 1'b0, 16'h0000);
    cycle_casc(1'b1, 1'b1, 16'h9998);
    cycle_casc(1'b1, 1'b0, 16'h0000);
    cycle_casc(1'b1, 1'b0, 16'h0000);
    cycle_casc(1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 150; i++) cycle_casc(1'b1, 1'b0, 16'h0000);

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bcd_counter_multi.md
# bcd_counter_multi

Parametrised multi-digit BCD counter, successor to the single-digit 4-bit BCD counter. Adds a configurable digit count, up/down counting, count enable, synchronous parallel load with BCD validation, and a terminal-count output for cascading. Used as a timebase and display counter feeding seven-segment drivers and higher-order counter stages.

## Interface
- DIGITS, 4, number of BCD digits (1..8); count width is 4*DIGITS
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock, reset is asynchronous and active-low
- en  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load strobe
- din  input  4*DIGITS  load value, digit 0 in bits [3:0]
- count  output  4*DIGITS  current BCD value, digit 0 least significant
- tc  output  1  terminal count (combinational)
- load_err  output  1  registered flag: last load contained a non-BCD digit

## Operation
- Reset (rst low): count = 0, load_err = 0, asynchronously; held while rst low.
- Priority per cycle: load > en > hold.
- load: each digit takes din digit if <= 9, else 0; load_err <= 1 if any din digit > 9, else 0. Count does not step on a load cycle even if en is high.
- en, up = 1: digit 0 increments; digit k increments when all lower digits are 9; a digit at 9 with carry-in becomes 0.
- en, up = 0: digit 0 decrements; digit k decrements when all lower digits are 0; a digit at 0 with borrow-in becomes 9.
- Wrap (default): all-9 +1 -> all-0; all-0 -1 -> all-9.
- tc = en & ~load & (up ? count == all-9 : count == all-0). Cascade: next stage en = tc of this stage.
- load_err holds its value until the next load cycle; en cycles do not change it.
- Direction change takes effect on the cycle up is sampled; no pipeline state.
- Count never holds a non-BCD digit.

## Timing
- count updates on the rising clk edge where load or en is high; latency 1 cycle.
- tc is combinational from count, en, up, load; valid in the same cycle, no register stage.
- load_err updates on the load edge, visible the next cycle.
- rst assertion mid-count clears count immediately; first step after release occurs on the first clk edge with rst high and en high.

## Configuration
- BCD_CNT_SATURATE_EN defined: counter saturates. Increment at all-9 holds all-9; decrement at all-0 holds all-0. tc still asserts at the terminal value with en high, so cascaded stages still see the event.
- Undefined: wrap-around as in Operation.

## Structure
- Package bcd_pkg: constant BCD_MAX = 4'd9, BCD_MIN = 4'd0, digit typedef (4-bit), function is_bcd(digit).
- Sub-module bcd_digit: one digit with inputs step, up, load, din and outputs q, at_max, at_min. Instantiated DIGITS times by generate. Carry/borrow enables are formed in the top level from the lower digits' at_max/at_min.

## Test plan
- DIGITS=2, rst low then high, en=1, up=1 for 100 cycles -> count 00..99 in BCD sequence, never hex A-F; tc high only in the cycle count=99; then 00.
- up=0 from 00 with en=1 -> next count 99 (wrap); with BCD_CNT_SATURATE_EN -> stays 00; tc high in both builds.
- load=1, en=1, din=8'h47 -> count 47 next cycle, no step; load_err=0.
- load with din=8'h3C -> count 30; load_err=1; then en steps leave load_err=1 until a valid load of 8'h12 clears it.
- Drive rst low mid-count at count=58 between clock edges -> count 00 immediately; release, en=1 -> 01 after the first edge.
- Cascade two DIGITS=2 instances (second en = first tc), up=1 -> combined value steps 0099 -> 0100; tc of the upper instance at 9999.
